// File: rtl/uart_sched_pkg.sv
// Shared types for the UART TX scheduler: FSM state encoding and the tag-byte builder
// used when UART_SCHED_TAG_EN is defined.
package uart_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_LAUNCH_TAG = 3'd3,
    ST_WAIT_TAG   = 3'd4
  } state_e;

  // Tag announces which requester the following payload byte came from.
  function automatic logic [7:0] tag_byte(input logic [3:0] mark, input logic [2:0] id);
    return {mark, 1'b0, id};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bus between byte producers / UART transmitter and the scheduler, plus FSM state for observation.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import uart_sched_pkg::*;

  // Producer handshake: a byte moves when i_Req_Valid[k] & o_Req_Ready[k] on a rising edge;
  // valid and data hold until ready, ready is a one-cycle pulse and is not a promise to wait.
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [NUM_REQ*8-1:0] i_Req_Data;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic                 o_Busy;
  logic [ID_W-1:0]      o_Grant_Id;
  logic [STATE_W-1:0]   o_State;

  modport master (
    output i_Req_Valid, i_Req_Data, i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_TX_DV, o_TX_Byte, o_Busy, o_Grant_Id, o_State
  );

  modport slave (
    input  i_Req_Valid, i_Req_Data, i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_TX_DV, o_TX_Byte, o_Busy, o_Grant_Id, o_State
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, searching modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int              idx;
  logic [ID_W-1:0] sel;

  // Walk from the farthest offset down so the nearest valid requester wins the last write.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (req[sel]) begin
        grant_idx = sel;
        any       = 1'b1;
      end
    end
    grant_oh = any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_SCHED_TAG_EN to precede every payload byte with a requester tag byte.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef UART_SCHED_TAG_EN
  , parameter logic [3:0] TAG_MARK = 4'hA
`endif
) (
  input  logic               i_Clock,
  input  logic               i_Rst_L,
  uart_tx_scheduler_if.slave bus
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
`ifdef UART_SCHED_TAG_EN
  logic [7:0]      data_q, data_d;
`endif

  logic [NUM_REQ-1:0] arb_oh;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [7:0]         req_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.i_Req_Valid),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign req_byte = bus.i_Req_Data[{arb_idx, 3'b000} +: 8];

  // Ready and the launch strobe are decoded from the registered state so that a byte
  // accepted in IDLE can launch on the very next cycle.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_d         = grant_q;
    tx_byte_d       = tx_byte_q;
`ifdef UART_SCHED_TAG_EN
    data_d          = data_q;
`endif
    bus.o_Req_Ready = '0;
    bus.o_TX_DV     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any && !i_Rst_L) begin
          bus.o_Req_Ready = arb_oh;
          grant_d         = arb_idx;
`ifdef UART_SCHED_TAG_EN
          data_d          = req_byte;
          tx_byte_d       = tag_byte(TAG_MARK, 3'(arb_idx));
          state_d         = ST_LAUNCH_TAG;
`else
          tx_byte_d       = req_byte;
          state_d         = ST_LAUNCH;
`endif
        end
      end
`ifdef UART_SCHED_TAG_EN
      ST_LAUNCH_TAG: begin
        if (!bus.i_TX_Active && !i_Rst_L) begin
          bus.o_TX_DV = 1'b1;
          state_d     = ST_WAIT_TAG;
        end
      end
      ST_WAIT_TAG: begin
        if (bus.i_TX_Done) begin
          tx_byte_d = data_q;
          state_d   = ST_LAUNCH;
        end
      end
`endif
      ST_LAUNCH: begin
        if (!bus.i_TX_Active && !i_Rst_L) begin
          bus.o_TX_DV = 1'b1;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.i_TX_Done) begin
          ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst_L) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_byte_q <= '0;
`ifdef UART_SCHED_TAG_EN
      data_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_byte_q <= tx_byte_d;
`ifdef UART_SCHED_TAG_EN
      data_q    <= data_d;
`endif
    end
  end

  assign bus.o_TX_Byte  = tx_byte_q;
  assign bus.o_Grant_Id = grant_q;
  assign bus.o_Busy     = (state_q != ST_IDLE);
  assign bus.o_State    = state_q;

endmodule
